// File: rtl/lookahead_seq_adder_if.sv
// lookahead_seq_adder_if: operand/result handshakes plus the 4-bit external adder link.
interface lookahead_seq_adder_if #(parameter int NSLICE = 4);
    localparam int W = 4 * NSLICE;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         cin;
    logic [3:0]   nib_a;
    logic [3:0]   nib_b;
    logic         nib_cin;
    logic [3:0]   nib_s;
    logic         nib_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         cout;
    logic         ovf;
    modport master (
        output in_valid, A, B, cin, out_ready, nib_s, nib_cout,
        input  in_ready, nib_a, nib_b, nib_cin, out_valid, S, cout, ovf
    );
    modport slave (
        input  in_valid, A, B, cin, out_ready, nib_s, nib_cout,
        output in_ready, nib_a, nib_b, nib_cin, out_valid, S, cout, ovf
    );
endinterface

// File: rtl/lookahead_seq_adder.sv
// lookahead_seq_adder: W-bit adder built by streaming 4-bit slices, LSB first,
// through an external combinational lookahead adder, one slice per cycle.
module lookahead_seq_adder #(
    parameter int NSLICE = 4
) (
    input logic                 Clk,
    input logic                 Reset_n,
    lookahead_seq_adder_if.slave bus
);
    localparam int W  = 4 * NSLICE;
    localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t        state, next;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_r, b_r, a_sh, b_sh;
    logic          cin_r, carry, last;

    assign a_sh = a_r >> {cnt, 2'b00};
    assign b_sh = b_r >> {cnt, 2'b00};
    assign last = cnt == CW'(NSLICE - 1);

    always_comb begin
        next          = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.nib_a     = 4'd0;
        bus.nib_b     = 4'd0;
        bus.nib_cin   = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) next = ADD;
            end
            ADD: begin
                bus.nib_a   = a_sh[3:0];
                bus.nib_b   = b_sh[3:0];
                bus.nib_cin = cnt == '0 ? cin_r : carry;
                if (last) next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n) state <= IDLE;
        else          state <= next;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            cin_r    <= 1'b0;
            carry    <= 1'b0;
            bus.S    <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            a_r   <= bus.A;
            b_r   <= bus.B;
            cin_r <= bus.cin;
            cnt   <= '0;
        end else if (state == ADD) begin
            bus.S[{cnt, 2'b00} +: 4] <= bus.nib_s;
            carry <= bus.nib_cout;
            cnt   <= cnt + 1'b1;
            // carry into the sign bit is a^b^s there, so ovf = that ^ carry out
            if (last) begin
                bus.cout <= bus.nib_cout;
                bus.ovf  <= a_r[W-1] ^ b_r[W-1] ^ bus.nib_s[3] ^ bus.nib_cout;
            end
        end
    end
endmodule
